serial_symbol_serializer: RTL

- Upstream stage of the serial bit sequence decoder. Accepts parallel SYMBOL_WIDTH-bit symbols over a valid/ready handshake and buffers them in a small FIFO.
- Emits them MSB-first as a gap-free serial bit stream, one bit per clock. The downstream decoder frames every SYMBOL_WIDTH bits from reset, so the stream never pauses.
- When no symbol is queued at a frame boundary, an idle symbol is inserted. The all-ones symbol flags an error downstream and can be filtered out here.

---
 rtl/serial_symbol_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_symbol_serializer.sv
// serial_symbol_serializer
// Upstream stage of the serial bit sequence decoder. Parallel symbols arrive
// over a valid/ready handshake, wait in a small FIFO, and leave MSB-first as a
// gap-free serial stream. The downstream decoder frames every SYMBOL_WIDTH
// bits counted from reset, so the stream never pauses: an idle symbol is
// inserted whenever nothing is queued at a frame boundary.

module serial_symbol_serializer #(
    parameter int                      SYMBOL_WIDTH = 3,
    parameter int                      FIFO_DEPTH   = 4,
    parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL  = '0,
    parameter bit                      DROP_ILLEGAL = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SYMBOL_WIDTH-1:0]           sym_data,
    input  logic                              sym_valid,
    output logic                              sym_ready,
    output logic                              out_bit,
    output logic                              frame_start,
    output logic                              idle_insert,
    output logic                              illegal_seen,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PHASE_W = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYMBOL_WIDTH - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    // Symbol storage; pointers wrap naturally because the depth is a power of two
    logic [SYMBOL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    // Serializer state
    logic [SYMBOL_WIDTH-1:0] shift_reg;
    logic [PHASE_W-1:0]      phase;

    // Per-edge decisions
    logic                    accept;
    logic                    sym_is_ones;
    logic                    do_write;
    logic                    drop_now;
    logic                    boundary;
    logic                    do_pop;
    logic [SYMBOL_WIDTH-1:0] load_sym;
    logic [SYMBOL_WIDTH-1:0] shifted;

    // Ready depends only on the registered level, so a pop on the same edge
    // never lets a write slip into a full FIFO
    assign sym_ready = (fifo_level < LEVEL_FULL);

    // Handshake, illegal-symbol filtering and frame-boundary decisions
    always_comb begin
        accept      = sym_valid && sym_ready;
        sym_is_ones = &sym_data;
        drop_now    = accept && DROP_ILLEGAL && sym_is_ones;
        do_write    = accept && !drop_now;
        boundary    = (phase == PHASE_LAST);
        do_pop      = boundary && (fifo_level != '0);
        load_sym    = (fifo_level != '0) ? fifo_mem[rd_ptr] : IDLE_SYMBOL;
        shifted     = shift_reg << 1;
    end

    // FIFO storage is data-only and needs no reset; the pointers define validity
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            fifo_mem[wr_ptr] <= sym_data;
        end
    end

    // FIFO pointers and occupancy; a write and a pop on one edge cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_write, do_pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky flag recording that an all-ones symbol was discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_seen <= 1'b0;
        end else if (drop_now) begin
            illegal_seen <= 1'b1;
        end
    end

    // Serializer: load a queued or idle symbol at each boundary, otherwise
    // shift; the phase starts at its last value so the first edge frames
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            phase       <= PHASE_LAST;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            idle_insert <= 1'b0;
        end else if (boundary) begin
            shift_reg   <= load_sym;
            out_bit     <= load_sym[SYMBOL_WIDTH-1];
            frame_start <= 1'b1;
            idle_insert <= (fifo_level == '0);
            phase       <= '0;
        end else begin
            shift_reg   <= shifted;
            out_bit     <= shifted[SYMBOL_WIDTH-1];
            frame_start <= 1'b0;
            idle_insert <= 1'b0;
            phase       <= phase + PHASE_ONE;
        end
    end

endmodule
